sha256_core_arbiter: RTL and testbench
======================================

# sha256_core_arbiter

Shares one SHA-256 core between `NUM_REQ` requesters, at message granularity. It grants one requester at a time, round-robin. It streams that requester's 512-bit blocks into the core's message port with correct `msg_nxt` chaining. It routes the final 256-bit digest back as a one-cycle response. It sits between the requester-side logic and the core's `msg_*`/`hash_*` port.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `CNT_W`, default 16: width of the block counter.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in NUM_REQ: requester i presents a block.
- `req_data` in NUM_REQ×512: packed `[NUM_REQ-1:0][511:0]`, one block per requester.
- `req_last` in NUM_REQ: the presented block is the final block of its message.
- `req_ready` out NUM_REQ: block accepted when `req_valid[i] && req_ready[i]`.
- `rsp_valid` out NUM_REQ: one-cycle pulse; the digest on `rsp_hash` belongs to requester i.
- `rsp_hash` out 256: digest, shared by all requesters.
- `core_msg_data` out 512: block to the core.
- `core_msg_valid` out 1: block offered to the core.
- `core_msg_nxt` out 1: 0 = start a new message (IV load); 1 = chain from the previous digest.
- `core_msg_rdy` in 1: core can accept a block.
- `core_hash_data` in 256: core digest.
- `core_hash_valid` in 1: one-cycle pulse; digest for the last accepted block is valid.
- `busy` out 1: state ≠ IDLE.
- `gnt_id` out $clog2(NUM_REQ): current or last grantee.
- `blk_cnt` out CNT_W: blocks accepted in the current message; saturates.
- `spurious_hash` out 1: sticky; set when `core_hash_valid` arrives outside WAIT_HASH.

## Operation
- States are IDLE, ISSUE, WAIT_HASH, RESPOND.
- **IDLE**
  - If any `req_valid` is high, pick the first set bit searching upward from `rr_ptr` (with wrap).
  - Register `gnt_id`, set `first`=1, clear `blk_cnt`, go to ISSUE.
- **ISSUE**
  - `core_msg_valid = req_valid[gnt_id]` and `core_msg_data = req_data[gnt_id]`, both combinational.
  - `core_msg_nxt = ~first`.
  - `req_ready[gnt_id] = core_msg_rdy`; all other `req_ready` bits are 0.
  - On handshake: latch `last = req_last[gnt_id]`, clear `first`, increment `blk_cnt`, go to WAIT_HASH.
- **WAIT_HASH**
  - `core_msg_valid`=0 and all `req_ready`=0.
  - On `core_hash_valid`: if `last`, capture `core_hash_data` into `rsp_hash` and go to RESPOND; otherwise go to ISSUE.
- **RESPOND**
  - `rsp_valid[gnt_id]`=1 for exactly one cycle.
  - `rr_ptr <= (gnt_id+1) mod NUM_REQ`; go to IDLE.
- **Grant lock:** the grant is held for the whole message. If the grantee drops `req_valid` mid-message, stay in ISSUE indefinitely; there is no timeout.
- **Core outputs outside ISSUE:** `core_msg_valid`=0 and `core_msg_data`=0.
- **Spurious hash:** `core_hash_valid` in IDLE, ISSUE or RESPOND is ignored for routing and sets `spurious_hash`. Only reset clears it.
- **Single-block message:** the block goes out with `core_msg_nxt`=0 and is also flagged as `last`.
- **Reset:** asserting `rst_n` in any state returns to IDLE immediately. A partial message is abandoned; the requester must restart it with `first`=1.
- **Reset values:**
  - state = IDLE, `rr_ptr` = 0, `gnt_id` = 0, `blk_cnt` = 0.
  - `rsp_hash` = 0, `rsp_valid` = 0, `req_ready` = 0.
  - `core_msg_valid` = 0, `core_msg_nxt` = 0, `core_msg_data` = 0.
  - `busy` = 0, `spurious_hash` = 0.

## Timing
- Request to core offer: `req_valid` first seen in IDLE at cycle t gives `core_msg_valid` at t+1.
- Digest to response: `core_hash_valid` at cycle t (for the last block) gives `rsp_valid` at t+1. The next arbitration decision happens at t+2 (in IDLE).
- Next block: `core_hash_valid` at cycle t (not last) gives the next block offered at t+1.
- Minimum idle gap between messages is 2 cycles (RESPOND, then IDLE).
- **Simultaneous events:**
  - A request arriving during RESPOND is seen in the following IDLE cycle.
  - `core_hash_valid` together with `core_msg_rdy` in WAIT_HASH: only the hash is acted on.
- **Width rules:**
  - `blk_cnt` saturates at 2^CNT_W−1.
  - `rr_ptr` wraps modulo `NUM_REQ`; `NUM_REQ` need not be a power of two.

## Structure
- Package `sha256_arb_pkg`: `MSG_W`=512, `HASH_W`=256, and `arb_state_e` {IDLE, ISSUE, WAIT_HASH, RESPOND}.
- Sub-module `sha256_rr_pick`: combinational rotate-priority picker (`req`, `ptr` → `gnt_oh`, `gnt_id`, `any`). It is reused by future multi-core schedulers.
- Top level: FSM, data mux, `rsp_hash` register, counters.

## Test plan
- **Reset and single block:** requester 2 sends one block `{512{1'b1}}` with `last`=1; the core model returns `32'hDEADBEEF` replicated.
  - Expect `core_msg_nxt`=0.
  - Expect `rsp_valid`=4'b0100 for 1 cycle, one cycle after `core_hash_valid`, with `rsp_hash` = the model digest.
- **Multi-block chaining:** requester 0 sends 3 blocks.
  - Expect `core_msg_nxt` sequence 0,1,1 and `blk_cnt`=3.
  - Expect exactly one `rsp_valid[0]` pulse, after the 3rd hash only.
- **Round robin:** all 4 requesters hold `req_valid`, one block each, from reset.
  - Expect grant order 0,1,2,3,0.
  - Expect no interleaving of blocks from different requesters.
- **Backpressure and valid drop:** `core_msg_rdy` held low for 10 cycles, and the grantee drops `req_valid` for 5 cycles mid-message.
  - Expect no handshake, grant held, and `req_ready` to the others = 0 throughout.
- **Spurious and reset:** pulse `core_hash_valid` in IDLE, which sets `spurious_hash`=1. Then assert `rst_n`=0 during WAIT_HASH of a 2-block message.
  - Expect all outputs at their reset values and `spurious_hash`=0.
  - Expect the next message to start with `core_msg_nxt`=0.

Source files
------------

// File: rtl/sha256_arb_pkg.sv
// Shared widths and FSM encoding for the SHA-256 core arbiter.
package sha256_arb_pkg;

    localparam int unsigned MSG_W  = 512;
    localparam int unsigned HASH_W = 256;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_HASH,
        RESPOND
    } arb_state_e;

endpackage

// File: rtl/sha256_rr_pick.sv
// Combinational rotate-priority picker: first set request at or above ptr, with wrap.
module sha256_rr_pick
    import sha256_arb_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt_oh,
    output logic [ID_W-1:0] gnt_id,
    output logic            any
);

    // Walk the requests starting at ptr; wrap is a subtract so N need not be a power of two.
    always_comb begin : pick
        int unsigned idx;
        gnt_oh = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any && req[ID_W'(idx)]) begin
                any                 = 1'b1;
                gnt_oh[ID_W'(idx)]  = 1'b1;
                gnt_id              = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sha256_core_arbiter.sv
// Message-granular round-robin arbiter sharing one SHA-256 core among NUM_REQ requesters.
module sha256_core_arbiter
    import sha256_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][MSG_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [HASH_W-1:0]              rsp_hash,
    output logic [MSG_W-1:0]               core_msg_data,
    output logic                           core_msg_valid,
    output logic                           core_msg_nxt,
    input  logic                           core_msg_rdy,
    input  logic [HASH_W-1:0]              core_hash_data,
    input  logic                           core_hash_valid,
    output logic                           busy,
    output logic [ID_W-1:0]                gnt_id,
    output logic [CNT_W-1:0]               blk_cnt,
    output logic                           spurious_hash
);

    arb_state_e           state;
    arb_state_e           state_nxt;
    logic [ID_W-1:0]      rr_ptr;
    logic [NUM_REQ-1:0]   pick_oh;
    logic [ID_W-1:0]      pick_id;
    logic                 pick_any;
    logic [NUM_REQ-1:0]   gnt_oh;
    logic                 first;
    logic                 last;
    logic                 msg_hs;

    sha256_rr_pick #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .gnt_oh (pick_oh),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    assign msg_hs = (state == ISSUE) && req_valid[gnt_id] && core_msg_rdy;
    assign busy   = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the grantee-steered core and requester handshake outputs.
    always_comb begin
        state_nxt      = state;
        core_msg_valid = 1'b0;
        core_msg_data  = '0;
        core_msg_nxt   = 1'b0;
        req_ready      = '0;
        rsp_valid      = '0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                core_msg_valid = req_valid[gnt_id];
                core_msg_data  = req_data[gnt_id];
                core_msg_nxt   = ~first;
                req_ready      = core_msg_rdy ? gnt_oh : '0;
                if (msg_hs) begin
                    state_nxt = WAIT_HASH;
                end
            end
            WAIT_HASH: begin
                if (core_hash_valid) begin
                    state_nxt = last ? RESPOND : ISSUE;
                end
            end
            RESPOND: begin
                rsp_valid = gnt_oh;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, chaining flags, block counter, digest capture, rr pointer and spurious flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_id        <= '0;
            gnt_oh        <= '0;
            rr_ptr        <= '0;
            first         <= 1'b0;
            last          <= 1'b0;
            blk_cnt       <= '0;
            rsp_hash      <= '0;
            spurious_hash <= 1'b0;
        end else begin
            if (core_hash_valid && (state != WAIT_HASH)) begin
                spurious_hash <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt_id  <= pick_id;
                        gnt_oh  <= pick_oh;
                        first   <= 1'b1;
                        blk_cnt <= '0;
                    end
                end
                ISSUE: begin
                    if (msg_hs) begin
                        last  <= req_last[gnt_id];
                        first <= 1'b0;
                        if (blk_cnt != '1) begin
                            blk_cnt <= blk_cnt + CNT_W'(1);
                        end
                    end
                end
                WAIT_HASH: begin
                    if (core_hash_valid && last) begin
                        rsp_hash <= core_hash_data;
                    end
                end
                RESPOND: begin
                    rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_core_arbiter.sv
// Self-checking bench: directed scenarios then randomized traffic against a message-level model.
module tb_sha256_core_arbiter;
    import sha256_arb_pkg::*;

    localparam int N    = 4;
    localparam int IDW  = 2;
    localparam int CW   = 2;
    localparam int MAXB = 64;

    localparam logic [HASH_W-1:0] IV    = {8{32'h6a09e667}};
    localparam logic [HASH_W-1:0] FIXED = {8{32'hDEADBEEF}};

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [N-1:0]               req_valid;
    logic [N-1:0][MSG_W-1:0]    req_data;
    logic [N-1:0]               req_last;
    logic [N-1:0]               req_ready;
    logic [N-1:0]               rsp_valid;
    logic [HASH_W-1:0]          rsp_hash;
    logic [MSG_W-1:0]           core_msg_data;
    logic                       core_msg_valid;
    logic                       core_msg_nxt;
    logic                       core_msg_rdy;
    logic [HASH_W-1:0]          core_hash_data;
    logic                       core_hash_valid;
    logic                       busy;
    logic [IDW-1:0]             gnt_id;
    logic [CW-1:0]              blk_cnt;
    logic                       spurious_hash;

    sha256_core_arbiter #(
        .NUM_REQ (N),
        .CNT_W   (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_last        (req_last),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_hash        (rsp_hash),
        .core_msg_data   (core_msg_data),
        .core_msg_valid  (core_msg_valid),
        .core_msg_nxt    (core_msg_nxt),
        .core_msg_rdy    (core_msg_rdy),
        .core_hash_data  (core_hash_data),
        .core_hash_valid (core_hash_valid),
        .busy            (busy),
        .gnt_id          (gnt_id),
        .blk_cnt         (blk_cnt),
        .spurious_hash   (spurious_hash)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Requester-side message store: each requester walks its block list in order.
    logic [MSG_W-1:0] bd [N][MAXB];
    bit               bl [N][MAXB];
    int               cnt [N];
    int               pos [N];
    int               mst [N];

    // Stimulus knobs.
    bit valid_off [N];
    int drop_pct;
    int rdy_pct;
    bit rdy_low;
    int dly_min;
    int dly_max;
    bit inject_spur;
    bit fixed_en;

    // Message-level reference state.
    bit              m_idle, m_issue, m_wait, m_first, m_last, rsp_due, exp_spur;
    int              owner, ptr, exp_blk;
    logic [HASH_W-1:0] ref_chain, exp_digest;
    int              grant_log [$];

    // Core behavioural model.
    int              cd;
    logic [HASH_W-1:0] core_chain, pend_digest;

    task automatic check_eq(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] x;
        for (int i = 0; i < 16; i++) x[i*32 +: 32] = $urandom;
        return x;
    endfunction

    function automatic logic [HASH_W-1:0] mix(input logic [HASH_W-1:0] prev, input logic [MSG_W-1:0] blk);
        return ({prev[HASH_W-2:0], prev[HASH_W-1]} + blk[511:256]) ^ blk[255:0];
    endfunction

    function automatic int pick_rr(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (v[idx]) return idx;
        end
        return 0;
    endfunction

    function automatic bit all_done();
        bit d;
        d = m_idle && !rsp_due;
        for (int r = 0; r < N; r++) if (pos[r] != cnt[r]) d = 0;
        return d;
    endfunction

    task automatic add_msg(input int r, input int nb, input bit ones);
        for (int b = 0; b < nb; b++) begin
            bd[r][cnt[r]] = ones ? '1 : rnd512();
            bl[r][cnt[r]] = (b == nb - 1);
            cnt[r]++;
        end
    endtask

    task automatic model_reset();
        m_idle = 1; m_issue = 0; m_wait = 0; m_first = 0; m_last = 0;
        rsp_due = 0; exp_spur = 0; exp_blk = 0; ptr = 0; owner = 0;
        cd = 0; inject_spur = 0;
        for (int r = 0; r < N; r++) pos[r] = mst[r];
    endtask

    task automatic drive();
        logic [511:0] junk;
        for (int r = 0; r < N; r++) begin
            bit has;
            has = pos[r] < cnt[r];
            req_valid[r] = has && !valid_off[r] && ($urandom_range(99) >= drop_pct);
            req_data[r]  = has ? bd[r][pos[r]] : rnd512();
            req_last[r]  = has ? bl[r][pos[r]] : 1'($urandom_range(1));
        end
        core_msg_rdy    = !rdy_low && ($urandom_range(99) < rdy_pct);
        junk            = rnd512();
        core_hash_valid = 1'b0;
        core_hash_data  = junk[255:0];
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                core_hash_valid = 1'b1;
                core_hash_data  = pend_digest;
            end
        end else if (inject_spur) begin
            core_hash_valid = 1'b1;
            inject_spur     = 0;
        end
    endtask

    task automatic monitor();
        logic [N-1:0] v;
        bit           rdy, hv, spur_now;
        logic [511:0] blk;
        v   = req_valid;
        rdy = core_msg_rdy;
        hv  = core_hash_valid;
        check_eq("busy", 512'(busy), 512'(!m_idle));
        if (!m_idle) check_eq("gnt_id", 512'(gnt_id), 512'(owner));
        check_eq("blk_cnt", 512'(blk_cnt), 512'(exp_blk));
        check_eq("rsp_valid", 512'(rsp_valid), rsp_due ? 512'(1 << owner) : 512'(0));
        if (rsp_due) check_eq("rsp_hash", 512'(rsp_hash), 512'(exp_digest));
        check_eq("core_msg_valid", 512'(core_msg_valid), 512'(m_issue && v[owner]));
        check_eq("req_ready", 512'(req_ready), (m_issue && rdy) ? 512'(1 << owner) : 512'(0));
        if (!m_issue) begin
            check_eq("core_msg_data_off", core_msg_data, 512'(0));
        end else if (v[owner]) begin
            check_eq("core_msg_data", core_msg_data, bd[owner][pos[owner]]);
            check_eq("core_msg_nxt", 512'(core_msg_nxt), 512'(!m_first));
        end
        check_eq("spurious_hash", 512'(spurious_hash), 512'(exp_spur));

        spur_now = hv && !m_wait;
        if (rsp_due) begin
            rsp_due = 0;
            m_idle  = 1;
            ptr     = (owner + 1) % N;
        end else if (m_idle) begin
            if (v != '0) begin
                owner = pick_rr(v, ptr);
                grant_log.push_back(owner);
                m_idle = 0; m_issue = 1; m_first = 1; exp_blk = 0;
            end
        end else if (m_issue) begin
            if (v[owner] && rdy) begin
                blk       = bd[owner][pos[owner]];
                m_last    = bl[owner][pos[owner]];
                ref_chain = m_first ? mix(IV, blk) : mix(ref_chain, blk);
                if (m_last) exp_digest = fixed_en ? FIXED : ref_chain;
                core_chain  = core_msg_nxt ? mix(core_chain, core_msg_data) : mix(IV, core_msg_data);
                pend_digest = fixed_en ? FIXED : core_chain;
                cd          = $urandom_range(dly_max, dly_min);
                pos[owner]++;
                if (m_last) mst[owner] = pos[owner];
                m_first = 0; m_issue = 0; m_wait = 1;
                if (exp_blk < (1 << CW) - 1) exp_blk++;
            end
        end else if (m_wait && hv) begin
            m_wait = 0;
            if (m_last) rsp_due = 1;
            else        m_issue = 1;
        end
        if (spur_now) exp_spur = 1;
    endtask

    task automatic cycle();
        drive();
        @(negedge clk);
        if (rst_n) monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        drive();
        @(negedge clk);
        check_eq("rst_busy", 512'(busy), 512'(0));
        check_eq("rst_gnt_id", 512'(gnt_id), 512'(0));
        check_eq("rst_blk_cnt", 512'(blk_cnt), 512'(0));
        check_eq("rst_rsp_hash", 512'(rsp_hash), 512'(0));
        check_eq("rst_rsp_valid", 512'(rsp_valid), 512'(0));
        check_eq("rst_req_ready", 512'(req_ready), 512'(0));
        check_eq("rst_core_msg_valid", 512'(core_msg_valid), 512'(0));
        check_eq("rst_core_msg_nxt", 512'(core_msg_nxt), 512'(0));
        check_eq("rst_core_msg_data", core_msg_data, 512'(0));
        check_eq("rst_spurious_hash", 512'(spurious_hash), 512'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_drain(input string tag, input int bound);
        int k;
        k = 0;
        while (!all_done() && k < bound) begin
            cycle();
            k++;
        end
        check_eq(tag, 512'(all_done()), 512'(1));
    endtask

    task automatic run_until_pos(input int r, input int target, input int bound);
        int k;
        k = 0;
        while (pos[r] != target && k < bound) begin
            cycle();
            k++;
        end
        check_eq("handshake_reached", 512'(pos[r]), 512'(target));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    initial begin
        int start;
        int exp_order [5];
        for (int r = 0; r < N; r++) begin
            cnt[r] = 0; pos[r] = 0; mst[r] = 0; valid_off[r] = 0;
        end
        drop_pct = 0; rdy_pct = 100; rdy_low = 0;
        dly_min = 1; dly_max = 1; fixed_en = 0;
        core_chain = '0; pend_digest = '0; ref_chain = '0; exp_digest = '0;
        req_valid = '0; req_data = '0; req_last = '0;
        core_msg_rdy = 1'b0; core_hash_valid = 1'b0; core_hash_data = '0;
        rst_n = 1'b0;
        do_reset();

        // Single all-ones block from requester 2 with a fixed core digest.
        fixed_en = 1;
        add_msg(2, 1, 1);
        run_drain("t1_drain", 40);
        fixed_en = 0;
        check_eq("t1_grantee", 512'(grant_log[$]), 512'(2));

        // Three-block chained message from requester 0.
        add_msg(0, 3, 0);
        run_drain("t2_drain", 60);
        check_eq("t2_blk_cnt", 512'(blk_cnt), 512'(3));

        // Round robin from reset with every requester pending.
        do_reset();
        grant_log.delete();
        for (int r = 0; r < N; r++) add_msg(r, 1, 0);
        add_msg(0, 1, 0);
        run_drain("t3_drain", 200);
        exp_order = '{0, 1, 2, 3, 0};
        check_eq("t3_grant_count", 512'(grant_log.size()), 512'(5));
        for (int i = 0; i < 5; i++) begin
            if (i < grant_log.size()) check_eq("t3_grant_order", 512'(grant_log[i]), 512'(exp_order[i]));
        end

        // Backpressure and mid-message valid drop; rr pointer now sits at 1.
        add_msg(0, 1, 0);
        add_msg(1, 2, 0);
        add_msg(3, 1, 0);
        start = pos[1];
        run_until_pos(1, start + 1, 50);
        rdy_low = 1;
        valid_off[1] = 1;
        for (int i = 0; i < 5; i++) cycle();
        valid_off[1] = 0;
        for (int i = 0; i < 5; i++) cycle();
        check_eq("t4_no_handshake", 512'(pos[1]), 512'(start + 1));
        check_eq("t4_grant_held", 512'(gnt_id), 512'(1));
        check_eq("t4_busy", 512'(busy), 512'(1));
        rdy_low = 0;
        run_drain("t4_drain", 100);

        // Spurious digest in IDLE, then reset in WAIT_HASH of a two-block message.
        inject_spur = 1;
        cycle();
        cycle();
        check_eq("t5_spurious_set", 512'(spurious_hash), 512'(1));
        dly_min = 6; dly_max = 6;
        add_msg(3, 2, 0);
        start = pos[3];
        run_until_pos(3, start + 1, 50);
        cycle();
        cycle();
        do_reset();
        dly_min = 1; dly_max = 1;
        check_eq("t5_rewound", 512'(pos[3]), 512'(start));
        run_drain("t5_drain", 100);
        check_eq("t5_regrant", 512'(grant_log[$]), 512'(3));

        // Randomized traffic: valid drops, core backpressure, variable digest latency.
        drop_pct = 20; rdy_pct = 70; dly_min = 1; dly_max = 4;
        for (int r = 0; r < N; r++) begin
            for (int m = 0; m < 3; m++) add_msg(r, int'($urandom_range(5, 1)), 0);
        end
        run_drain("rand_drain", 3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
